sr_lsu: RTL and testbench

- Load/store unit between the control decoder's data-memory outputs (dmWe, dmSign, dmOpByte/Half/Word) and a word-wide, valid/ready data-memory bus.
- Converts one byte/half/word CPU access into one or two aligned word beats, generating byte enables and lane-rotated write data.
- For loads, assembles, shifts and sign/zero-extends read data.
- Stalls the single-cycle core until the access completes.

---
 rtl/sr_lsu_pkg.sv | 59 +++++
 rtl/sr_lsu_if.sv | 23 ++
 rtl/sr_lsu_lane.sv | 54 +++++
 rtl/sr_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_sr_lsu.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access sizes,
// size decode, straddle detection and store-lane rotation.
package sr_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ0  = 3'd1,
    LSU_WAIT0 = 3'd2,
    LSU_REQ1  = 3'd3,
    LSU_WAIT1 = 3'd4,
    LSU_DONE  = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    DM_BYTE = 2'd0,
    DM_HALF = 2'd1,
    DM_WORD = 2'd2
  } dm_size_e;

  // Word wins over half wins over byte; an empty selection means word.
  function automatic dm_size_e decode_size(input logic op_byte, input logic op_half,
                                           input logic op_word);
    dm_size_e size;
    if (op_word) begin
      size = DM_WORD;
    end else if (op_half) begin
      size = DM_HALF;
    end else if (op_byte) begin
      size = DM_BYTE;
    end else begin
      size = DM_WORD;
    end
    return size;
  endfunction

  // An access straddles when its bytes cross into the next aligned word.
  function automatic logic straddles(input dm_size_e size, input logic [1:0] a);
    logic res;
    case (size)
      DM_WORD: res = (a != 2'd0);
      DM_HALF: res = (a == 2'd3);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] res;
    case (a)
      2'd0:    res = d;
      2'd1:    res = {d[23:0], d[31:24]};
      2'd2:    res = {d[15:0], d[31:16]};
      2'd3:    res = {d[7:0],  d[31:8]};
      default: res = d;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_lsu_if.sv
// Word-wide valid/ready data-memory bus with a separate read-return channel.
interface sr_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              memValid;
  logic              memReady;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [3:0]        memBe;
  logic [31:0]       memWData;
  logic              memRValid;
  logic [31:0]       memRData;

  modport master (
    output memValid, memWe, memAddr, memBe, memWData,
    input  memReady, memRValid, memRData
  );

  modport slave (
    input  memValid, memWe, memAddr, memBe, memWData,
    output memReady, memRValid, memRData
  );
endinterface

// File: rtl/sr_lsu_lane.sv
// Combinational lane logic: beat count and byte enables for an access, and
// shift/extension of the assembled two-word read data.
module sr_lsu_lane
  import sr_lsu_pkg::*;
(
  input  dm_size_e    size,
  input  logic [1:0]  a,
  input  logic        sign,
  input  logic [63:0] assembled,
  output logic        two_beat,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // byte enables for both beats
  always_comb begin
    two_beat = straddles(size, a);
    be0      = 4'b0000;
    be1      = 4'b0000;
    case (size)
      DM_BYTE: be0 = 4'b0001 << a;
      DM_HALF: begin
        if (a == 2'd3) begin
          be0 = 4'b1000;
          be1 = 4'b0001;
        end else begin
          be0 = 4'b0011 << a;
        end
      end
      DM_WORD: begin
        be0 = 4'b1111 << a;
        be1 = 4'b1111 >> (3'd4 - {1'b0, a});
      end
      default: be0 = 4'b1111;
    endcase
  end

  // align the addressed byte to bit 0, then extend to the access size
  always_comb begin
    shifted = 32'(assembled >> {a, 3'b000});
    case (size)
      DM_BYTE: result = sign ? {{24{shifted[7]}}, shifted[7:0]}
                             : {24'h000000, shifted[7:0]};
      DM_HALF: result = sign ? {{16{shifted[15]}}, shifted[15:0]}
                             : {16'h0000, shifted[15:0]};
      DM_WORD: result = shifted;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/sr_lsu.sv
// Load/store unit: turns one byte/half/word CPU access into one or two aligned
// bus beats and stalls the core until the access completes.
module sr_lsu
  import sr_lsu_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmReq,
  input  logic              dmWe,
  input  logic              dmSign,
  input  logic              dmOpByte,
  input  logic              dmOpHalf,
  input  logic              dmOpWord,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [31:0]       dmWData,
  output logic [31:0]       dmRData,
  output logic              dmStall,
  output logic              dmDone,
  output logic              dmMisalign,
  sr_lsu_if.master          mem
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  lsu_state_e        state_r, state_nxt;
  dm_size_e          size_r, size_nxt;
  logic [1:0]        a_r, a_nxt;
  logic              sign_r, sign_nxt;
  logic              mis_lat_r, mis_lat_nxt;
  logic [31:0]       beat0_r, beat0_nxt;

  logic              valid_r, valid_nxt;
  logic              mem_we_r, mem_we_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic [3:0]        be_r, be_nxt;
  logic [31:0]       wdata_r, wdata_nxt;
  logic [31:0]       rdata_r, rdata_nxt;
  logic              done_r, done_nxt;
  logic              misalign_r, misalign_nxt;

  dm_size_e          in_size_s;
  logic              force_align_s;
  logic [1:0]        in_a_s;
  dm_size_e          lane_size_s;
  logic [1:0]        lane_a_s;
  logic [63:0]       assembled_s;
  logic              lane_two_s;
  logic [3:0]        lane_be0_s;
  logic [3:0]        lane_be1_s;
  logic [31:0]       lane_result_s;

  // decode the incoming request; misaligned accesses collapse to a=0 when not split
  always_comb begin
    in_size_s     = decode_size(dmOpByte, dmOpHalf, dmOpWord);
    force_align_s = straddles(in_size_s, dmAddr[1:0]) && (ALLOW_MISALIGNED == 1'b0);
    in_a_s        = force_align_s ? 2'b00 : dmAddr[1:0];
    lane_size_s   = (state_r == LSU_IDLE) ? in_size_s : size_r;
    lane_a_s      = (state_r == LSU_IDLE) ? in_a_s : a_r;
    assembled_s   = (state_r == LSU_WAIT1) ? {mem.memRData, beat0_r}
                                           : {32'h00000000, mem.memRData};
  end

  sr_lsu_lane u_lane (
    .size      (lane_size_s),
    .a         (lane_a_s),
    .sign      (sign_r),
    .assembled (assembled_s),
    .two_beat  (lane_two_s),
    .be0       (lane_be0_s),
    .be1       (lane_be1_s),
    .result    (lane_result_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_nxt    = state_r;
    size_nxt     = size_r;
    a_nxt        = a_r;
    sign_nxt     = sign_r;
    mis_lat_nxt  = mis_lat_r;
    beat0_nxt    = beat0_r;
    valid_nxt    = 1'b0;
    mem_we_nxt   = mem_we_r;
    addr_nxt     = addr_r;
    be_nxt       = be_r;
    wdata_nxt    = wdata_r;
    rdata_nxt    = rdata_r;
    done_nxt     = 1'b0;
    misalign_nxt = 1'b0;
    case (state_r)
      LSU_IDLE: begin
        if (dmReq) begin
          size_nxt    = in_size_s;
          a_nxt       = in_a_s;
          sign_nxt    = dmSign;
          mis_lat_nxt = force_align_s;
          valid_nxt   = 1'b1;
          mem_we_nxt  = dmWe;
          addr_nxt    = {dmAddr[ADDR_W-1:2], 2'b00};
          be_nxt      = lane_be0_s;
          wdata_nxt   = rotl_bytes(dmWData, in_a_s);
          state_nxt   = LSU_REQ0;
        end else begin
          state_nxt = LSU_IDLE;
        end
      end
      LSU_REQ0: begin
        if (mem.memReady) begin
          if (!mem_we_r) begin
            state_nxt = LSU_WAIT0;
          end else if (lane_two_s) begin
            valid_nxt = 1'b1;
            addr_nxt  = addr_r + WORD_STEP;
            be_nxt    = lane_be1_s;
            state_nxt = LSU_REQ1;
          end else begin
            done_nxt     = 1'b1;
            misalign_nxt = mis_lat_r;
            state_nxt    = LSU_DONE;
          end
        end else begin
          valid_nxt = 1'b1;
        end
      end
      LSU_WAIT0: begin
        if (mem.memRValid) begin
          beat0_nxt = mem.memRData;
          if (lane_two_s) begin
            valid_nxt = 1'b1;
            addr_nxt  = addr_r + WORD_STEP;
            be_nxt    = lane_be1_s;
            state_nxt = LSU_REQ1;
          end else begin
            rdata_nxt    = lane_result_s;
            done_nxt     = 1'b1;
            misalign_nxt = mis_lat_r;
            state_nxt    = LSU_DONE;
          end
        end else begin
          state_nxt = LSU_WAIT0;
        end
      end
      LSU_REQ1: begin
        if (mem.memReady) begin
          if (mem_we_r) begin
            done_nxt     = 1'b1;
            misalign_nxt = mis_lat_r;
            state_nxt    = LSU_DONE;
          end else begin
            state_nxt = LSU_WAIT1;
          end
        end else begin
          valid_nxt = 1'b1;
        end
      end
      LSU_WAIT1: begin
        if (mem.memRValid) begin
          rdata_nxt    = lane_result_s;
          done_nxt     = 1'b1;
          misalign_nxt = mis_lat_r;
          state_nxt    = LSU_DONE;
        end else begin
          state_nxt = LSU_WAIT1;
        end
      end
      LSU_DONE: state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  // state, latched operands and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= LSU_IDLE;
      size_r     <= DM_WORD;
      a_r        <= 2'b00;
      sign_r     <= 1'b0;
      mis_lat_r  <= 1'b0;
      beat0_r    <= 32'h00000000;
      valid_r    <= 1'b0;
      mem_we_r   <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      be_r       <= 4'b0000;
      wdata_r    <= 32'h00000000;
      rdata_r    <= 32'h00000000;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      size_r     <= size_nxt;
      a_r        <= a_nxt;
      sign_r     <= sign_nxt;
      mis_lat_r  <= mis_lat_nxt;
      beat0_r    <= beat0_nxt;
      valid_r    <= valid_nxt;
      mem_we_r   <= mem_we_nxt;
      addr_r     <= addr_nxt;
      be_r       <= be_nxt;
      wdata_r    <= wdata_nxt;
      rdata_r    <= rdata_nxt;
      done_r     <= done_nxt;
      misalign_r <= misalign_nxt;
    end
  end

  assign mem.memValid = valid_r;
  assign mem.memWe    = mem_we_r;
  assign mem.memAddr  = addr_r;
  assign mem.memBe    = be_r;
  assign mem.memWData = wdata_r;
  assign dmRData      = rdata_r;
  assign dmDone       = done_r;
  assign dmMisalign   = misalign_r;
  assign dmStall      = dmReq & ~done_r;

endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: a bus model checks every accepted beat
// against a queue of expected beats; scenario tasks check load results and timing.
module tb_sr_lsu;
  import sr_lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dmReq, dmWe, dmSign, dmOpByte, dmOpHalf, dmOpWord;
  logic [31:0] dmAddr, dmWData, dmRData;
  logic        dmStall, dmDone, dmMisalign;

  logic        b_req, b_we, b_sign, b_byte, b_half, b_word;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_stall, b_done, b_misalign;

  sr_lsu_if #(.ADDR_W(32)) bus_a ();
  sr_lsu_if #(.ADDR_W(32)) bus_b ();

  sr_lsu #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .dmReq(dmReq), .dmWe(dmWe), .dmSign(dmSign),
    .dmOpByte(dmOpByte), .dmOpHalf(dmOpHalf), .dmOpWord(dmOpWord),
    .dmAddr(dmAddr), .dmWData(dmWData), .dmRData(dmRData), .dmStall(dmStall),
    .dmDone(dmDone), .dmMisalign(dmMisalign), .mem(bus_a)
  );

  sr_lsu #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_aligned (
    .clk(clk), .rst(rst), .dmReq(b_req), .dmWe(b_we), .dmSign(b_sign),
    .dmOpByte(b_byte), .dmOpHalf(b_half), .dmOpWord(b_word),
    .dmAddr(b_addr), .dmWData(b_wdata), .dmRData(b_rdata), .dmStall(b_stall),
    .dmDone(b_done), .dmMisalign(b_misalign), .mem(bus_b)
  );

  int          errors = 0;
  int          checks = 0;
  beat_t       exp_beats[$];
  logic [31:0] mem_words [int unsigned];
  logic        mute = 1'b0;
  logic        force_rvalid = 1'b0;
  logic [31:0] force_rdata = 32'h0;

  // bus model: check accepted beats, apply writes, return read data one cycle later
  always @(posedge clk) begin
    logic        rv;
    logic [31:0] rd;
    logic [31:0] w;
    int unsigned idx;
    beat_t       e;
    rv = force_rvalid;
    rd = force_rdata;
    if (!rst && bus_a.memValid === 1'b1 && bus_a.memReady === 1'b1) begin
      idx = int'(bus_a.memAddr[31:2]);
      checks++;
      if (exp_beats.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got we=%b addr=%h be=%b", bus_a.memWe, bus_a.memAddr, bus_a.memBe);
      end else begin
        e = exp_beats.pop_front();
        if (bus_a.memWe !== e.we || bus_a.memAddr !== e.addr || bus_a.memBe !== e.be ||
            (e.we && bus_a.memWData !== e.wdata)) begin
          errors++;
          $display("FAIL beat: got we=%b addr=%h be=%b wdata=%h, expected we=%b addr=%h be=%b wdata=%h",
                   bus_a.memWe, bus_a.memAddr, bus_a.memBe, bus_a.memWData, e.we, e.addr, e.be, e.wdata);
        end
      end
      w = mem_words.exists(idx) ? mem_words[idx] : 32'h0;
      if (bus_a.memWe) begin
        for (int i = 0; i < 4; i++) begin
          if (bus_a.memBe[i]) w[8*i +: 8] = bus_a.memWData[8*i +: 8];
        end
        mem_words[idx] = w;
      end else if (!mute) begin
        rv = 1'b1;
        rd = w;
      end
    end
    #1;
    bus_a.memRValid = rv;
    bus_a.memRData  = rd;
  end

  function automatic beat_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
    beat_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
    return b;
  endfunction

  // drive one access on DUT A and observe it; lat = -1 if it never completes
  task automatic run_access(input logic we, input dm_size_e sz, input logic sign,
                            input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                            output int lat, output logic [31:0] rd, output int stall_bad,
                            output logic [31:0] held_addr, output logic [3:0] held_be);
    @(negedge clk);
    dmReq = 1'b1; dmWe = we; dmSign = sign;
    dmOpByte = (sz == DM_BYTE); dmOpHalf = (sz == DM_HALF); dmOpWord = (sz == DM_WORD);
    dmAddr = addr; dmWData = wdata;
    bus_a.memReady = (stall == 0);
    lat = -1; rd = 32'h0; stall_bad = 0; held_addr = 32'h0; held_be = 4'b0000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= stall) begin
        if (c == 1) begin
          held_addr = bus_a.memAddr;
          held_be   = bus_a.memBe;
        end
        if (bus_a.memValid !== 1'b1 || bus_a.memAddr !== held_addr || bus_a.memBe !== held_be)
          stall_bad++;
        dmAddr  = dmAddr ^ 32'h00000F0D;
        dmWData = ~dmWData;
        if (c == stall) bus_a.memReady = 1'b1;
      end
      if (dmDone === 1'b1) begin
        lat = c;
        rd  = dmRData;
        break;
      end else if (dmStall !== 1'b1) begin
        stall_bad++;
      end
    end
    dmReq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmReq = 1'b0; dmWe = 1'b0; dmSign = 1'b0; dmOpByte = 1'b0; dmOpHalf = 1'b0; dmOpWord = 1'b0;
    dmAddr = 32'h0; dmWData = 32'h0; bus_a.memReady = 1'b1;
    b_req = 1'b0; b_we = 1'b0; b_sign = 1'b0; b_byte = 1'b0; b_half = 1'b0; b_word = 1'b0;
    b_addr = 32'h0; b_wdata = 32'h0; bus_b.memReady = 1'b1; bus_b.memRValid = 1'b0; bus_b.memRData = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_a.memValid !== 1'b0 || bus_a.memWe !== 1'b0 || bus_a.memBe !== 4'b0000 || bus_a.memAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got valid=%b we=%b be=%b addr=%h, expected all 0", bus_a.memValid, bus_a.memWe, bus_a.memBe, bus_a.memAddr);
    end
    checks++;
    if (bus_a.memWData !== 32'h0 || dmRData !== 32'h0 || dmDone !== 1'b0 || dmMisalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_core: got wdata=%h rdata=%h done=%b mis=%b, expected all 0", bus_a.memWData, dmRData, dmDone, dmMisalign);
    end
    dmReq = 1'b1;
    #1;
    checks++;
    if (dmStall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 1", dmStall);
    end
    dmReq = 1'b0;
    #1;
    checks++;
    if (dmStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_low: got %b expected 0", dmStall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sw_aligned();
    int lat, sb; logic [31:0] rd, ha; logic [3:0] hb;
    exp_beats.push_back(mk(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF));
    run_access(1'b1, DM_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 0, lat, rd, sb, ha, hb);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++;
    if (sb !== 0) begin errors++; $display("FAIL sw_stall: got %0d violations expected 0", sb); end
    checks++;
    if (mem_words[32'h40] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_mem: got %h expected deadbeef", mem_words[32'h40]);
    end
  endtask

  task automatic test_lb();
    int lat, sb; logic [31:0] rd, ha; logic [3:0] hb;
    mem_words[32'h40] = 32'h80112233;
    exp_beats.push_back(mk(1'b0, 32'h100, 4'b1000, 32'h0));
    run_access(1'b0, DM_BYTE, 1'b1, 32'h103, 32'h0, 0, lat, rd, sb, ha, hb);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", rd); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    exp_beats.push_back(mk(1'b0, 32'h100, 4'b1000, 32'h0));
    run_access(1'b0, DM_BYTE, 1'b0, 32'h103, 32'h0, 0, lat, rd, sb, ha, hb);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", rd); end
  endtask

  task automatic test_lh_split();
    int lat, sb; logic [31:0] rd, ha; logic [3:0] hb;
    mem_words[32'h80] = 32'hAB000000;
    mem_words[32'h81] = 32'h000000CD;
    exp_beats.push_back(mk(1'b0, 32'h200, 4'b1000, 32'h0));
    exp_beats.push_back(mk(1'b0, 32'h204, 4'b0001, 32'h0));
    run_access(1'b0, DM_HALF, 1'b1, 32'h203, 32'h0, 0, lat, rd, sb, ha, hb);
    checks++;
    if (rd !== 32'hFFFFCDAB) begin errors++; $display("FAIL lh_split_data: got %h expected ffffcdab", rd); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL lh_split_latency: got %0d expected 5", lat); end
    checks++;
    if (exp_beats.size() != 0) begin
      errors++; $display("FAIL lh_split_beats: got %0d beats missing expected 0", exp_beats.size());
    end
  endtask

  task automatic test_sw_split();
    int lat, sb; logic [31:0] rd, ha; logic [3:0] hb;
    mem_words[32'h41] = 32'h00000000;
    exp_beats.push_back(mk(1'b1, 32'h100, 4'b1110, 32'h33221144));
    exp_beats.push_back(mk(1'b1, 32'h104, 4'b0001, 32'h33221144));
    run_access(1'b1, DM_WORD, 1'b0, 32'h101, 32'h44332211, 0, lat, rd, sb, ha, hb);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sw_split_latency: got %0d expected 3", lat); end
    exp_beats.push_back(mk(1'b0, 32'h100, 4'b1110, 32'h0));
    exp_beats.push_back(mk(1'b0, 32'h104, 4'b0001, 32'h0));
    run_access(1'b0, DM_WORD, 1'b0, 32'h101, 32'h0, 0, lat, rd, sb, ha, hb);
    checks++;
    if (rd !== 32'h44332211) begin errors++; $display("FAIL lw_split_readback: got %h expected 44332211", rd); end
  endtask

  task automatic test_backpressure();
    int lat, sb; logic [31:0] rd, ha; logic [3:0] hb;
    mem_words[32'hC0] = 32'h55667788;
    exp_beats.push_back(mk(1'b0, 32'h300, 4'b1100, 32'h0));
    run_access(1'b0, DM_HALF, 1'b0, 32'h302, 32'h0, 4, lat, rd, sb, ha, hb);
    checks++;
    if (ha !== 32'h300 || hb !== 4'b1100) begin
      errors++; $display("FAIL stall_req: got addr=%h be=%b expected 00000300 1100", ha, hb);
    end
    checks++;
    if (sb !== 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", sb); end
    checks++;
    if (rd !== 32'h00005566 || lat !== 6) begin
      errors++; $display("FAIL stall_result: got data=%h lat=%0d expected 00005566 6", rd, lat);
    end
  endtask

  task automatic test_reset_midaccess();
    int lat, sb; logic [31:0] rd, ha; logic [3:0] hb;
    int bad;
    mute = 1'b1;
    exp_beats.push_back(mk(1'b0, 32'h400, 4'b1111, 32'h0));
    @(negedge clk);
    dmReq = 1'b1; dmWe = 1'b0; dmSign = 1'b0; dmOpByte = 1'b0; dmOpHalf = 1'b0; dmOpWord = 1'b1;
    dmAddr = 32'h400; bus_a.memReady = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dmStall !== 1'b1) begin errors++; $display("FAIL rst_stall_follow: got %b expected 1", dmStall); end
    @(negedge clk);
    rst = 1'b0; dmReq = 1'b0;
    force_rvalid = 1'b1; force_rdata = 32'hBAD0BAD0;
    checks++;
    if (bus_a.memValid !== 1'b0 || dmDone !== 1'b0) begin
      errors++; $display("FAIL rst_idle: got valid=%b done=%b expected 0 0", bus_a.memValid, dmDone);
    end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      force_rvalid = 1'b0;
      if (bus_a.memValid !== 1'b0 || dmDone !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_stale_rvalid: got %0d bad cycles expected 0", bad); end
    mute = 1'b0;
    mem_words[32'h100] = 32'h12345678;
    exp_beats.push_back(mk(1'b0, 32'h400, 4'b1111, 32'h0));
    run_access(1'b0, DM_WORD, 1'b0, 32'h400, 32'h0, 0, lat, rd, sb, ha, hb);
    checks++;
    if (rd !== 32'h12345678 || lat !== 3) begin
      errors++; $display("FAIL rst_recover: got data=%h lat=%0d expected 12345678 3", rd, lat);
    end
  endtask

  task automatic test_no_misalign();
    int nbeats, lat;
    logic pend, mis;
    logic [31:0] a_seen, rd;
    logic [3:0] be_seen;
    nbeats = 0; lat = -1; pend = 1'b0; mis = 1'b0; a_seen = 32'h0; be_seen = 4'b0; rd = 32'h0;
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_sign = 1'b0; b_byte = 1'b0; b_half = 1'b0; b_word = 1'b1;
    b_addr = 32'h102; bus_b.memReady = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus_b.memRValid = pend;
      bus_b.memRData  = 32'hCAFEF00D;
      pend = 1'b0;
      if (bus_b.memValid === 1'b1) begin
        nbeats++;
        a_seen = bus_b.memAddr;
        be_seen = bus_b.memBe;
        pend = 1'b1;
      end
      if (b_done === 1'b1) begin
        lat = c; rd = b_rdata; mis = b_misalign;
        break;
      end
    end
    b_req = 1'b0;
    checks++;
    if (nbeats != 1 || a_seen !== 32'h100 || be_seen !== 4'b1111) begin
      errors++; $display("FAIL noalign_beat: got beats=%0d addr=%h be=%b expected 1 00000100 1111", nbeats, a_seen, be_seen);
    end
    checks++;
    if (mis !== 1'b1 || rd !== 32'hCAFEF00D || lat !== 3) begin
      errors++; $display("FAIL noalign_done: got mis=%b data=%h lat=%0d expected 1 cafef00d 3", mis, rd, lat);
    end
    @(negedge clk);
    checks++;
    if (b_misalign !== 1'b0 || b_done !== 1'b0) begin
      errors++; $display("FAIL noalign_pulse: got mis=%b done=%b expected 0 0", b_misalign, b_done);
    end
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_lb();
    test_lh_split();
    test_sw_split();
    test_backpressure();
    test_reset_midaccess();
    test_no_misalign();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_beats.size() != 0) begin
      errors++; $display("FAIL beats_outstanding: got %0d expected 0", exp_beats.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
